// File: rtl/uart_pkg.sv
// Shared UART definitions: TX/RX FSM state encoding and default frame shape.
package uart_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam int DEF_DBIT    = 8;
  localparam int DEF_SB_TICK = 16;

  // Tick counter width: must reach 15 for start/data bits and SB_TICK-1 for stop.
  function automatic int s_width(input int sb_tick);
    return $clog2((sb_tick > 16) ? sb_tick : 16);
  endfunction

endpackage

// File: rtl/uart_tx_hold_if.sv
// Host-side write port of the UART transmitter holding register.
interface uart_tx_hold_if
  import uart_pkg::*;
#(parameter int DBIT = DEF_DBIT);

  logic            wr;
  logic [DBIT-1:0] din;
  logic            tx_full;
  logic            wr_drop_tick;

  modport master (output wr, din, input  tx_full, wr_drop_tick);
  modport slave  (input  wr, din, output tx_full, wr_drop_tick);

endinterface

// File: rtl/uart_tx_hold.sv
// UART transmitter: single-entry holding register feeding a 16x-oversampled
// TX shifter. The host sets the full flag, the shifter clears it on transfer.
module uart_tx_hold
  import uart_pkg::*;
#(
  parameter int DBIT    = DEF_DBIT,
  parameter int SB_TICK = DEF_SB_TICK
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           s_tick,
  uart_tx_hold_if.slave  host,
  output logic           tx_busy,
  output logic           tx_done_tick,
  output logic           tx
);

  localparam int SW = s_width(SB_TICK);
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [SW-1:0] S_LAST = SW'(15);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  logic [1:0]      r_state, w_state_nx;
  logic [SW-1:0]   r_s, w_s_nx;
  logic [NW-1:0]   r_n, w_n_nx;
  logic [DBIT-1:0] r_b, w_b_nx;
  logic [DBIT-1:0] r_hold;
  logic            r_full;
  logic            r_tx, w_tx_nx;
  logic            w_stop_end;
  logic            w_xfer;
  logic            w_accept;

  // A transfer empties the hold; a same-clk write refills it, so a write is
  // only refused when the hold is full and not being drained this clk.
  assign w_xfer   = r_full && ((r_state == ST_IDLE) || w_stop_end);
  assign w_accept = host.wr && (!r_full || w_xfer);

  // Shifter next-state: counters move only on s_tick; IDLE ignores ticks.
  always_comb begin
    w_state_nx = r_state;
    w_s_nx     = r_s;
    w_n_nx     = r_n;
    w_b_nx     = r_b;
    w_stop_end = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_full) begin
          w_state_nx = ST_START;
          w_s_nx     = '0;
          w_b_nx     = r_hold;
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (r_s == S_LAST) begin
            w_state_nx = ST_DATA;
            w_s_nx     = '0;
            w_n_nx     = '0;
          end else begin
            w_s_nx = r_s + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (r_s == S_LAST) begin
            w_s_nx = '0;
            w_b_nx = r_b >> 1;
            if (r_n == N_LAST) w_state_nx = ST_STOP;
            else               w_n_nx     = r_n + 1'b1;
          end else begin
            w_s_nx = r_s + 1'b1;
          end
        end
      end
      default: begin // ST_STOP
        if (s_tick) begin
          if (r_s == S_STOP) begin
            w_stop_end = 1'b1;
            if (r_full) begin
              // Chain straight into the next start bit: no idle gap.
              w_state_nx = ST_START;
              w_s_nx     = '0;
              w_b_nx     = r_hold;
            end else begin
              w_state_nx = ST_IDLE;
            end
          end else begin
            w_s_nx = r_s + 1'b1;
          end
        end
      end
    endcase
  end

  // Line level derived from the next state so the registered tx never glitches.
  always_comb begin
    w_tx_nx = 1'b1;
    case (w_state_nx)
      ST_START: w_tx_nx = 1'b0;
      ST_DATA:  w_tx_nx = w_b_nx[0];
      default:  w_tx_nx = 1'b1;
    endcase
  end

  // Shifter state, counters, data and line register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_b     <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nx;
      r_s     <= w_s_nx;
      r_n     <= w_n_nx;
      r_b     <= w_b_nx;
      r_tx    <= w_tx_nx;
    end
  end

  // Holding register and full flag: set by an accepted write, cleared by transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold <= '0;
      r_full <= 1'b0;
    end else begin
      if (w_accept) begin
        r_hold <= host.din;
        r_full <= 1'b1;
      end else if (w_xfer) begin
        r_full <= 1'b0;
      end
    end
  end

  assign tx                = r_tx;
  assign tx_busy           = (r_state != ST_IDLE);
  assign tx_done_tick      = w_stop_end;
  assign host.tx_full      = r_full;
  assign host.wr_drop_tick = host.wr && !w_accept;

endmodule

// File: tb/tb_uart_tx_hold.sv
// Bench for uart_tx_hold: tick-level frame model drives expectations, a
// separate monitor decodes tx frames and checks them against a byte queue.
module tb_uart_tx_hold;

  localparam int FR_TICKS = 16 * (8 + 1) + 16;   // start + 8 data + 1 stop

  logic clk = 1'b0;
  logic reset;
  logic s_tick;
  logic tx_busy, tx_done_tick, tx;
  logic tx_busy2, tx_done_tick2, tx2;

  uart_tx_hold_if #(.DBIT(8)) hif ();
  uart_tx_hold_if #(.DBIT(7)) hif2 ();

  uart_tx_hold #(.DBIT(8), .SB_TICK(16)) u_dut (
    .clk(clk), .reset(reset), .s_tick(s_tick), .host(hif),
    .tx_busy(tx_busy), .tx_done_tick(tx_done_tick), .tx(tx)
  );

  uart_tx_hold #(.DBIT(7), .SB_TICK(32)) u_dut2 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .host(hif2),
    .tx_busy(tx_busy2), .tx_done_tick(tx_done_tick2), .tx(tx2)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural model: a frame is FR_TICKS ticks long; the hold is one slot.
  logic       m_full = 1'b0;
  logic       m_busy = 1'b0;
  int         m_left = 0;
  logic [7:0] exp_q[$];
  int         tcnt = 0;
  int         cyc = 0;
  int         done_last = 0, done_prev = 0;
  logic       wr2_n = 1'b0;
  logic [6:0] din2_n = '0;

  task automatic step(input logic w, input logic [7:0] d);
    logic tk, stop_end, xfer, acc;
    @(posedge clk); #1;
    tk = (tcnt % 4 == 0);
    tcnt++;
    s_tick = tk; hif.wr = w; hif.din = d; hif2.wr = wr2_n; hif2.din = din2_n;
    stop_end = m_busy && tk && (m_left == 1);
    xfer     = m_full && (!m_busy || stop_end);
    acc      = w && (!m_full || xfer);
    if (acc) exp_q.push_back(d);
    @(negedge clk);
    chk("tx_full", hif.tx_full, m_full);
    chk("tx_busy", tx_busy, m_busy);
    chk("wr_drop_tick", hif.wr_drop_tick, w && !acc);
    chk("tx_done_tick", tx_done_tick, stop_end);
    if (tx_done_tick) begin done_prev = done_last; done_last = cyc; end
    if (m_busy && tk) begin
      m_left--;
      if (m_left == 0) m_busy = 1'b0;
    end
    if (xfer) begin m_busy = 1'b1; m_left = FR_TICKS; end
    if (acc) m_full = 1'b1;
    else if (xfer) m_full = 1'b0;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 5000 && (m_busy || m_full); i++) step(1'b0, 8'h00);
    chk("idle_timeout", {m_busy, m_full}, 2'b00);
    idle(3);
  endtask

  task automatic wait_busy();
    for (int i = 0; i < 100 && !m_busy; i++) step(1'b0, 8'h00);
    chk("busy_timeout", m_busy, 1'b1);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    reset = 1'b1; s_tick = 1'b0; hif.wr = 1'b0; hif2.wr = 1'b0;
    tcnt++; cyc++;
    #1;
    chk("rst_tx", tx, 1'b1);
    chk("rst_full", hif.tx_full, 1'b0);
    chk("rst_busy", tx_busy, 1'b0);
    chk("rst_done", tx_done_tick, 1'b0);
    chk("rst_tx2", tx2, 1'b1);
    m_full = 1'b0; m_busy = 1'b0; m_left = 0;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; tcnt++; cyc++; end
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: decode frames on tx by counting s_ticks from the start edge.
  logic       mon_act = 1'b0;
  int         mon_cnt = 0;
  logic [7:0] mon_rx  = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        mon_act = 1'b0;
      end else if (!mon_act) begin
        if (tx === 1'b0) begin
          mon_act = 1'b1;
          mon_cnt = s_tick ? 1 : 0;
          mon_rx  = '0;
        end
      end else if (s_tick) begin
        mon_cnt++;
        if (mon_cnt % 16 == 8) begin
          if (mon_cnt / 16 == 0)      chk("mon_start", tx, 1'b0);
          else if (mon_cnt / 16 <= 8) mon_rx[mon_cnt / 16 - 1] = tx;
          else                        chk("mon_stop", tx, 1'b1);
        end
        if (mon_cnt == FR_TICKS) begin
          chk("mon_done", tx_done_tick, 1'b1);
          if (exp_q.size() == 0) chk("mon_frame_expected", 0, 1);
          else                   chk("mon_byte", mon_rx, exp_q.pop_front());
          mon_act = 1'b0;
        end
      end
    end
  end

  int   c2;
  logic seen2;

  initial begin
    reset = 1'b1; s_tick = 1'b0;
    hif.wr = 1'b0; hif.din = '0; hif2.wr = 1'b0; hif2.din = '0;
    #1;
    chk("init_tx", tx, 1'b1);
    chk("init_full", hif.tx_full, 1'b0);
    chk("init_busy", tx_busy, 1'b0);
    chk("init_drop", hif.wr_drop_tick, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    idle(4);

    // Single byte with two-edge latency to the start bit.
    step(1'b1, 8'hA5);
    step(1'b0, 8'h00);
    chk("lat_full", hif.tx_full, 1'b1);
    chk("lat_tx_hi", tx, 1'b1);
    step(1'b0, 8'h00);
    chk("lat_tx_lo", tx, 1'b0);
    chk("lat_full_clr", hif.tx_full, 1'b0);
    wait_idle();

    // Back-to-back frames: second start follows the stop directly.
    step(1'b1, 8'h3C);
    wait_busy();
    idle(100);
    step(1'b1, 8'hC3);
    wait_idle();
    chk("b2b_done_gap", done_last - done_prev, 640);

    // Overrun: third write while full is dropped.
    step(1'b1, 8'h11);
    wait_busy();
    idle(100);
    step(1'b1, 8'h22);
    idle(5);
    step(1'b1, 8'hFF);
    wait_idle();

    // Write on the exact clk the stop ends with the hold full.
    step(1'b1, 8'hAA);
    wait_busy();
    step(1'b1, 8'hBB);
    for (int i = 0; i < 2000 && !(m_busy && m_full && (tcnt % 4 == 0) && m_left == 1); i++)
      step(1'b0, 8'h00);
    step(1'b1, 8'hCC);
    chk("simul_no_drop", hif.wr_drop_tick, 1'b0);
    step(1'b0, 8'h00);
    chk("simul_full", hif.tx_full, 1'b1);
    wait_idle();

    // Random writes at random gaps, including overruns.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) step(1'b1, 8'($urandom));
      else                             step(1'b0, 8'h00);
    end
    wait_idle();

    // Reset during data bit 3 with a byte waiting in the hold.
    step(1'b1, 8'h12);
    wait_busy();
    step(1'b1, 8'h34);
    for (int i = 0; i < 1000 && m_left > FR_TICKS - (16 + 3 * 16 + 8); i++) step(1'b0, 8'h00);
    do_reset(2);
    idle(2);
    chk("post_rst_tx", tx, 1'b1);
    chk("post_rst_busy", tx_busy, 1'b0);
    step(1'b1, 8'h55);
    wait_idle();
    chk("queue_drained", exp_q.size(), 0);

    // DBIT=7, SB_TICK=32 instance: byte 0x41, two stop bits.
    wr2_n = 1'b1; din2_n = 7'h41;
    step(1'b0, 8'h00);
    wr2_n = 1'b0;
    step(1'b0, 8'h00);
    chk("d2_full", hif2.tx_full, 1'b1);
    step(1'b0, 8'h00);
    chk("d2_start", tx2, 1'b0);
    c2 = s_tick ? 1 : 0;
    seen2 = 1'b0;
    for (int i = 0; i < 1500 && !seen2; i++) begin
      step(1'b0, 8'h00);
      if (s_tick) begin
        c2++;
        if (c2 % 16 == 8 && c2 < 128) begin
          if (c2 / 16 == 0) chk("d2_startbit", tx2, 1'b0);
          else chk("d2_bit", tx2, (32'h41 >> (c2 / 16 - 1)) & 32'h1);
        end
        if (c2 > 128) chk("d2_stop", tx2, 1'b1);
      end
      if (tx_done_tick2) begin
        chk("d2_done_tick", c2, 16 * 8 + 32);
        seen2 = 1'b1;
      end
    end
    chk("d2_done_seen", seen2, 1'b1);
    idle(3);
    chk("d2_busy_end", tx_busy2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
